// File: rtl/bf16_pkg.sv
// Shared BF16 types and helpers for the min/max reduction datapath.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bf16_pkg;

  typedef logic [15:0] bf16_t;

  localparam bf16_t      BF16_CANON_NAN = 16'h7FC0;
  localparam logic [7:0] BF16_EXP_MAX   = 8'hFF;

  typedef enum logic {
    OP_MIN = 1'b0,
    OP_MAX = 1'b1
  } minmax_op_e;

  // NaN: all-ones exponent with a non-zero mantissa (infinities are ordinary values).
  function automatic logic bf16_is_nan(input bf16_t x);
    return (x[14:7] == BF16_EXP_MAX) && (x[6:0] != 7'd0);
  endfunction

  // Monotonic unsigned key: -inf < negatives < -0 < +0 < positives < +inf.
  function automatic logic [15:0] bf16_order_key(input bf16_t x);
    return x[15] ? ~x : (x ^ 16'h8000);
  endfunction

endpackage

// File: rtl/bf16_minmax_cmp.sv
// Combinational BF16 min/max select: decides whether a candidate replaces the accumulator.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the owning sequencer qualifies take_cand with its handshake.
import bf16_pkg::*;

module bf16_minmax_cmp (
  input  bf16_t      acc,
  input  bf16_t      cand,
  input  minmax_op_e op,
  output logic       take_cand,
  output logic       cand_nan
);

  logic [15:0] acc_key;
  logic [15:0] cand_key;

  assign acc_key  = bf16_order_key(acc);
  assign cand_key = bf16_order_key(cand);
  assign cand_nan = bf16_is_nan(cand);

  // Strict compare so equal keys keep the accumulator (first occurrence wins).
  always_comb begin
    take_cand = 1'b0;
    if (!cand_nan) begin
      if (op == OP_MAX) take_cand = (cand_key > acc_key);
      else              take_cand = (cand_key < acc_key);
    end
  end

endmodule

// File: rtl/bf16_minmax_reduce.sv
// Reduces a command-sized stream of BF16 elements to its min or max, skipping NaNs.
// Latency: result valid the cycle after the last element (or after a len=0 command).
// Backpressure: one element/cycle in ACCUM; result held in DONE until res_ready.
import bf16_pkg::*;

module bf16_minmax_reduce #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [LEN_W-1:0] res_count,
  output logic             res_all_nan
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  minmax_op_e       op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] elem_cnt;
  logic [LEN_W-1:0] elem_nxt;
  logic [LEN_W-1:0] nn_cnt;
  bf16_t            acc;
  logic             have_value;
  logic             take_cand;
  logic             cand_nan;
  logic             in_fire;

  // Handshake readiness comes only from registered state.
  assign cmd_ready = (state == ST_IDLE);
  assign in_ready  = (state == ST_ACCUM);
  assign res_valid = (state == ST_DONE);
  assign in_fire   = in_valid && in_ready;
  assign elem_nxt  = elem_cnt + LEN_W'(1);

  // Result fields are driven only while a result is offered; zero otherwise.
  assign res_data    = res_valid ? (have_value ? acc : BF16_CANON_NAN) : 16'h0000;
  assign res_count   = res_valid ? nn_cnt : '0;
  assign res_all_nan = res_valid && !have_value;

  bf16_minmax_cmp u_cmp (
    .acc       (acc),
    .cand      (in_data),
    .op        (op_q),
    .take_cand (take_cand),
    .cand_nan  (cand_nan)
  );

  // Command/element/result sequencing with accumulator and counter updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_MIN;
      len_q      <= '0;
      elem_cnt   <= '0;
      nn_cnt     <= '0;
      acc        <= 16'h0000;
      have_value <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q       <= minmax_op_e'(cmd_op);
            len_q      <= cmd_len;
            elem_cnt   <= '0;
            nn_cnt     <= '0;
            have_value <= 1'b0;
            state      <= (cmd_len == '0) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_fire) begin
            elem_cnt <= elem_nxt;
            if (!cand_nan) begin
              nn_cnt <= nn_cnt + LEN_W'(1);
              // First real value seeds the accumulator; later ones must win the compare.
              if (!have_value || take_cand) acc <= in_data;
              have_value <= 1'b1;
            end
            if (elem_nxt == len_q) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_minmax_reduce.sv
// Directed bench for bf16_minmax_reduce with hand-computed expected results.
// Latency: checks result one cycle after last element / empty command.
// Backpressure: exercises in_valid gaps and a stalled res_ready.
module tb_bf16_minmax_reduce;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [7:0]  cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [7:0]  res_count;
  logic        res_all_nan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf16_minmax_reduce #(.LEN_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_count   (res_count),
    .res_all_nan (res_all_nan)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic [7:0] len);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  // Sends n elements packed MSB-first in v; optional idle cycle before each later element.
  task automatic send_elems(input logic [63:0] v, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = v[63-16*i -: 16];
      while (!in_ready && w < 20) begin
        step();
        w++;
      end
      check("in_ready_wait", in_ready, 1);
      check("res_valid_in_accum", res_valid, 0);
      step();
    end
    in_valid = 1'b0;
  endtask

  // Expects the result offered now; takes it and checks return to IDLE next cycle.
  task automatic get_result(input string tag, input logic [15:0] d, input logic [7:0] c, input logic an);
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_data"}, res_data, d);
    check({tag, "_count"}, res_count, c);
    check({tag, "_all_nan"}, res_all_nan, an);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, res_valid, 0);
    check({tag, "_cmd_ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_len = 8'd0;
    in_valid = 1'b0; in_data = 16'h0000; res_ready = 1'b0;
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 16'h0000);
    check("rst_res_count", res_count, 0);
    check("rst_res_all_nan", res_all_nan, 0);
    reset = 1'b0;
    step();

    // Max / min over mixed values
    send_cmd(1'b1, 8'd4);
    send_elems(64'h3F80_C000_4040_0000, 4, 1'b0);
    get_result("max_mixed", 16'h4040, 8'd4, 1'b0);

    send_cmd(1'b0, 8'd4);
    send_elems(64'h3F80_C000_4040_0000, 4, 1'b0);
    get_result("min_mixed", 16'hC000, 8'd4, 1'b0);

    // NaN skipped, -inf wins min
    send_cmd(1'b0, 8'd3);
    send_elems(64'h7FC1_4000_FF80_0000, 3, 1'b0);
    get_result("min_nan_skip", 16'hFF80, 8'd2, 1'b0);

    // All-NaN and empty commands
    send_cmd(1'b1, 8'd2);
    send_elems(64'h7FC0_FFC1_0000_0000, 2, 1'b0);
    get_result("all_nan", 16'h7FC0, 8'd0, 1'b1);

    send_cmd(1'b1, 8'd0);
    get_result("len_zero", 16'h7FC0, 8'd0, 1'b1);

    // Signed zeros and ties
    send_cmd(1'b1, 8'd2);
    send_elems(64'h8000_0000_0000_0000, 2, 1'b0);
    get_result("max_zeros", 16'h0000, 8'd2, 1'b0);

    send_cmd(1'b0, 8'd2);
    send_elems(64'h8000_0000_0000_0000, 2, 1'b0);
    get_result("min_zeros", 16'h8000, 8'd2, 1'b0);

    send_cmd(1'b0, 8'd2);
    send_elems(64'h4000_4000_0000_0000, 2, 1'b0);
    get_result("min_tie", 16'h4000, 8'd2, 1'b0);

    // Input gaps, then result held under res_ready low
    send_cmd(1'b1, 8'd4);
    send_elems(64'h3F80_4040_C000_4000, 4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h7F80;
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, 16'h4040);
      check("hold_count", res_count, 8'd4);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    get_result("gaps_bp", 16'h4040, 8'd4, 1'b0);

    // Reset mid-ACCUM, with a command presented during reset
    send_cmd(1'b1, 8'd4);
    send_elems(64'h7F80_3F80_0000_0000, 2, 1'b0);
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    cmd_len   = 8'd1;
    step();
    cmd_valid = 1'b0;
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_res_valid", res_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("postrst_idle", cmd_ready, 1);
      check("postrst_no_result", res_valid, 0);
    end
    send_cmd(1'b0, 8'd1);
    send_elems(64'h4000_0000_0000_0000, 1, 1'b0);
    get_result("after_reset", 16'h4000, 8'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf16_minmax_reduce.md
# bf16_minmax_reduce

Sequencer that drives a combinational BF16 min/max comparator to reduce a stream of BF16 elements to a single minimum or maximum. It accepts one command (operation and length), consumes that many elements at up to one per cycle through a valid/ready port, and returns the result, the non-NaN element count and an all-NaN flag through a second valid/ready port. It sits between a vector load/stream source and the accelerator result path, and is the only owner of its comparator instance.

## Interface
- LEN_W, 8: width of cmd_len; a command covers at most 2^LEN_W-1 elements
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high in IDLE only
- cmd_op  in  1  0 = min, 1 = max
- cmd_len  in  LEN_W  number of elements to consume
- in_valid  in  1  element present
- in_ready  out  1  high in ACCUM only
- in_data  in  16  BF16 element
- res_valid  out  1  result present, high in DONE only
- res_ready  in  1  consumer accepts the result
- res_data  out  16  BF16 min/max
- res_count  out  LEN_W  number of non-NaN elements consumed
- res_all_nan  out  1  no non-NaN element was seen, including the len = 0 case

## Operation
- FSM states are IDLE, ACCUM and DONE. The reset state is IDLE.
- **IDLE:** When cmd_valid is high, latch op and len, clear the element counter, non-NaN count and have_value, then move to ACCUM. If len = 0, move directly to DONE with res_data = 16'h7FC0, res_all_nan = 1 and res_count = 0.
- **ACCUM:** Each in_valid & in_ready handshake increments the element counter.
  - A NaN element (exp = 8'hFF, man != 0) is skipped: it is counted as consumed but not as non-NaN.
  - The first non-NaN element loads the accumulator and sets have_value.
  - Each later non-NaN element replaces the accumulator when the comparator selects it.
  - The handshake of element len moves the FSM to DONE.
- **DONE:** Outputs are held stable until res_valid & res_ready, then the FSM returns to IDLE.
- **Ordering:** comparison uses an unsigned 16-bit key.
  - The key is ~x when the sign bit is set, and x ^ 16'h8000 otherwise.
  - This gives the total order -inf < negatives < -0 < +0 < positives < +inf, so -0 is strictly below +0.
- **Ties:** on equal keys the accumulator is kept, so the first occurrence wins.
- **res_data:** the accumulator if have_value is set, otherwise 16'h7FC0. res_all_nan = ~have_value.
- **Stream gaps:** in_valid gaps in ACCUM stall the reduction with no effect on the result.

## Timing
- **Reset values:** state IDLE, so cmd_ready = 1; in_ready = 0, res_valid = 0, res_data = 0, res_count = 0, res_all_nan = 0. Internal counters and have_value are cleared.
- **Reset mid-operation:** reset in any state forces IDLE on the next edge. Partial results are discarded and no res_valid is produced.
- **Handshakes during reset:** cmd and input handshakes presented while reset is high are ignored.
- **Ready signals:** cmd_ready, in_ready and res_valid are decoded from the registered state only and never depend combinationally on a valid input.
- **Command to first element:** a command is accepted at edge T. in_ready is first high in the cycle after T, and the first element can be accepted at edge T+1.
- **Throughput:** one element per cycle when in_valid is held high.
- **Latency:** the last element is accepted at edge E and res_valid is high from cycle E+1. A len = 0 command accepted at T gives res_valid from T+1.
- **Result return:** when res_ready is already high in the first DONE cycle, the result is taken at that edge and cmd_ready rises in the following cycle. The next command is accepted earliest one cycle after the result handshake, so back-to-back commands cost one result cycle plus one IDLE cycle.
- **res_count:** counts at most LEN_W-bit values; no wrap is possible because the count is at most cmd_len.

## Structure
- **Package bf16_pkg:**
  - bf16_t typedef (16-bit)
  - BF16_CANON_NAN = 16'h7FC0
  - BF16_EXP_MAX = 8'hFF
  - minmax_op_e enum (OP_MIN = 0, OP_MAX = 1)
  - functions bf16_is_nan() and bf16_order_key()
- **Sub-module bf16_minmax_cmp:** a purely combinational comparator.
  - Inputs: acc, cand and op.
  - Outputs: take_cand and cand_nan.
  - It is instantiated once inside bf16_minmax_reduce.
- The FSM, counters and accumulator registers live in the top module.

## Test plan
- **Max, mixed values:** op = 1, len = 4, elements 3F80, C000, 4040, 0000 -> res_data = 4040, res_count = 4, res_all_nan = 0, res_valid exactly 1 cycle after the 4th accept.
- **Min, same stream and skipped NaN:**
  - op = 0 on the same stream -> C000.
  - op = 0, len = 3, elements 7FC1, 4000, FF80 -> FF80, res_count = 2.
- **All-NaN and empty commands:**
  - len = 2, elements 7FC0, FFC1 -> res_data = 7FC0, res_all_nan = 1, res_count = 0.
  - len = 0 -> the same result one cycle after the command.
- **Signed zeros and ties:**
  - max over 8000, 0000 -> 0000.
  - min over the same -> 8000.
  - min over 4000, 4000 keeps the first; the result is checked as 4000.
- **Backpressure and gaps:** in_valid toggling 1-0-1-0 and res_ready held low 5 cycles -> res_data, res_count and res_valid stay stable, cmd_ready = 0 and in_ready = 0 throughout DONE. The result is accepted on the first res_ready cycle, and cmd_ready rises the next cycle.
- **Reset mid-ACCUM:** reset asserted after 2 of 4 elements of a max command (elements 7F80, 3F80) -> IDLE next edge, res_valid never asserted. A new min command with len = 1, element 4000, then returns 4000, proving no state was retained.
